// File: rtl/gpio_debounce_if.sv
// GPIO debounce signal bundle: raw inputs, configuration and interrupt controls
// (master side) plus debounced levels, edge pulses and pending flags (slave side).
interface gpio_debounce_if #(
    parameter int GW = 32,
    parameter int PW = 16,
    parameter int CW = 8
);
    logic [GW-1:0] gpio_i;
    logic [PW-1:0] cfg_pre;
    logic [CW-1:0] cfg_thr;
    logic [GW-1:0] irq_rise_en;
    logic [GW-1:0] irq_fall_en;
    logic [GW-1:0] pnd_clr;
    logic [GW-1:0] gpio_d;
    logic [GW-1:0] rise;
    logic [GW-1:0] fall;
    logic [GW-1:0] pnd;
    logic          irq;

    modport master (
        output gpio_i, cfg_pre, cfg_thr, irq_rise_en, irq_fall_en, pnd_clr,
        input  gpio_d, rise, fall, pnd, irq
    );

    modport slave (
        input  gpio_i, cfg_pre, cfg_thr, irq_rise_en, irq_fall_en, pnd_clr,
        output gpio_d, rise, fall, pnd, irq
    );
endinterface

// File: rtl/gpio_debounce.sv
// Per-bit GPIO debouncer: a shared prescaler tick advances a per-bit counter while
// the input disagrees with the debounced level; edges raise sticky pending flags.
module gpio_debounce #(
    parameter int             GW      = 32,
    parameter int             PW      = 16,
    parameter int             CW      = 8,
    parameter logic [GW-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    gpio_debounce_if.slave   bus
);
    logic [PW-1:0] pcnt;
    logic          tick;
    logic [CW-1:0] cnt [GW];
    logic [GW-1:0] level;
    logic [GW-1:0] rise_r;
    logic [GW-1:0] fall_r;
    logic [GW-1:0] pend;
    logic [GW-1:0] mism;
    logic [GW-1:0] flip;

    // >= rather than == so a lowered period ticks at once instead of wrapping.
    assign tick = (pcnt >= bus.cfg_pre);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_comb begin
        mism = bus.gpio_i ^ level;
        flip = '0;
        for (int i = 0; i < GW; i++) begin
            flip[i] = mism[i] & tick & (cnt[i] >= bus.cfg_thr);
        end
    end

    // The counter only increments while below the threshold, so it can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < GW; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < GW; i++) begin
                if (!mism[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    cnt[i] <= flip[i] ? '0 : cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level  <= RST_VAL;
            rise_r <= '0;
            fall_r <= '0;
            pend   <= '0;
        end else begin
            level  <= level ^ flip;
            rise_r <= flip & bus.gpio_i;
            fall_r <= flip & ~bus.gpio_i;
            // Set terms are ORed after the clear so a coincident edge wins.
            pend   <= (pend & ~bus.pnd_clr)
                    | (rise_r & bus.irq_rise_en)
                    | (fall_r & bus.irq_fall_en);
        end
    end

    assign bus.gpio_d = level;
    assign bus.rise   = rise_r;
    assign bus.fall   = fall_r;
    assign bus.pnd    = pend;
    assign bus.irq    = |pend;
endmodule

// File: tb/tb_gpio_debounce.sv
// Directed and randomized checks of gpio_debounce against a per-bit tick-run model.
module tb_gpio_debounce;
    localparam int GW = 16;
    localparam int PW = 8;
    localparam int CW = 8;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    gpio_debounce_if #(.GW(GW), .PW(PW), .CW(CW)) bus ();

    gpio_debounce #(.GW(GW), .PW(PW), .CW(CW), .RST_VAL('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a bit flips on the (thr+1)-th tick of an unbroken mismatch run.
    logic [GW-1:0] m_d;
    logic [GW-1:0] m_rise;
    logic [GW-1:0] m_fall;
    logic [GW-1:0] m_pnd;
    int            m_run [GW];
    int            m_since;

    task automatic model_reset();
        m_d     = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_pnd   = '0;
        m_since = 0;
        for (int i = 0; i < GW; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        bit            tk;
        logic [GW-1:0] nr;
        logic [GW-1:0] nf;
        tk    = (m_since >= int'(bus.cfg_pre));
        m_pnd = (m_pnd & ~bus.pnd_clr) | (m_rise & bus.irq_rise_en) | (m_fall & bus.irq_fall_en);
        nr    = '0;
        nf    = '0;
        for (int i = 0; i < GW; i++) begin
            if (bus.gpio_i[i] == m_d[i]) begin
                m_run[i] = 0;
            end else if (tk) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] > int'(bus.cfg_thr)) begin
                    nr[i]    = bus.gpio_i[i];
                    nf[i]    = ~bus.gpio_i[i];
                    m_d[i]   = bus.gpio_i[i];
                    m_run[i] = 0;
                end
            end
        end
        m_rise  = nr;
        m_fall  = nf;
        m_since = tk ? 0 : m_since + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        check("gpio_d", 32'(bus.gpio_d), 32'(m_d));
        check("rise",   32'(bus.rise),   32'(m_rise));
        check("fall",   32'(bus.fall),   32'(m_fall));
        check("pnd",    32'(bus.pnd),    32'(m_pnd));
        check("irq",    32'(bus.irq),    32'(|m_pnd));
    endtask

    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            #1;
            check_model();
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_gpio_d", 32'(bus.gpio_d), 32'h0);
        check("rst_rise",   32'(bus.rise),   32'h0);
        check("rst_fall",   32'(bus.fall),   32'h0);
        check("rst_pnd",    32'(bus.pnd),    32'h0);
        check("rst_irq",    32'(bus.irq),    32'h0);
    endtask

    // Called 1 time unit after a rising edge: asserts reset mid-cycle, releases at the negedge.
    task automatic async_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [GW-1:0] flips;
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b0;
        bus.gpio_i      = '0;
        bus.cfg_pre     = '0;
        bus.cfg_thr     = '0;
        bus.irq_rise_en = '0;
        bus.irq_fall_en = '0;
        bus.pnd_clr     = '0;
        model_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Zero period and threshold: one-cycle follow.
        cycle(2);
        bus.gpio_i[0] = 1'b1;
        cycle(1);
        check("follow_d0",    32'(bus.gpio_d[0]), 32'h1);
        check("follow_rise0", 32'(bus.rise[0]),   32'h1);
        cycle(1);
        check("rise0_pulse",  32'(bus.rise[0]),   32'h0);

        // Period 4, threshold 2: stable high debounces, 7-cycle glitch rejected.
        bus.cfg_pre   = 8'd3;
        bus.cfg_thr   = 8'd2;
        bus.gpio_i[5] = 1'b1;
        cycle(16);
        check("stable_d5", 32'(bus.gpio_d[5]), 32'h1);
        bus.gpio_i[5] = 1'b0;
        cycle(7);
        bus.gpio_i[5] = 1'b1;
        cycle(16);
        check("glitch_d5", 32'(bus.gpio_d[5]), 32'h1);

        // Falling-edge interrupt on bit 7 and its clear.
        bus.cfg_pre        = '0;
        bus.cfg_thr        = '0;
        bus.irq_fall_en[7] = 1'b1;
        bus.gpio_i[7]      = 1'b1;
        cycle(3);
        bus.gpio_i[7] = 1'b0;
        cycle(1);
        check("fall7", 32'(bus.fall[7]), 32'h1);
        cycle(1);
        check("pnd7_set", 32'(bus.pnd[7]), 32'h1);
        check("irq_set",  32'(bus.irq),    32'h1);
        bus.pnd_clr[7] = 1'b1;
        cycle(1);
        bus.pnd_clr[7] = 1'b0;
        check("pnd7_clr", 32'(bus.pnd[7]), 32'h0);
        check("irq_clr",  32'(bus.irq),    32'h0);

        // Clear coincident with a rise on bit 3: the set wins.
        bus.irq_rise_en[3] = 1'b1;
        bus.gpio_i[3]      = 1'b1;
        cycle(1);
        check("rise3", 32'(bus.rise[3]), 32'h1);
        bus.pnd_clr[3] = 1'b1;
        cycle(1);
        bus.pnd_clr[3] = 1'b0;
        check("set_wins3", 32'(bus.pnd[3]), 32'h1);
        cycle(2);

        // Threshold lowered under a running count on bit 2.
        bus.cfg_thr   = 8'd200;
        bus.gpio_i[2] = 1'b1;
        cycle(50);
        check("thr_hold_d2", 32'(bus.gpio_d[2]), 32'h0);
        bus.cfg_thr = 8'd5;
        cycle(1);
        check("thr_low_d2", 32'(bus.gpio_d[2]), 32'h1);

        // Period lowered under a running prescaler: tick right away.
        bus.cfg_thr   = '0;
        bus.cfg_pre   = 8'd200;
        bus.gpio_i[9] = 1'b1;
        cycle(60);
        check("pre_hold_d9", 32'(bus.gpio_d[9]), 32'h0);
        bus.cfg_pre = 8'd5;
        cycle(1);
        check("pre_low_d9", 32'(bus.gpio_d[9]), 32'h1);
        cycle(6);

        // Reset mid-count with all inputs high, then threshold 1 from a clean start.
        bus.cfg_pre     = '0;
        bus.cfg_thr     = 8'd1;
        bus.gpio_i      = '1;
        bus.irq_rise_en = '1;
        cycle(1);
        async_reset();
        cycle(1);
        check("post_rst_c1", 32'(bus.gpio_d), 32'h0);
        cycle(1);
        check("post_rst_d",    32'(bus.gpio_d), 32'(16'hFFFF));
        check("post_rst_rise", 32'(bus.rise),   32'(16'hFFFF));
        cycle(2);

        // Randomized phase: sticky inputs, occasional config changes and a mid-run reset.
        for (int n = 0; n < 1600; n++) begin
            if (n % 200 == 0) begin
                bus.cfg_pre     = PW'($urandom_range(0, 3));
                bus.cfg_thr     = CW'($urandom_range(0, 3));
                bus.irq_rise_en = GW'($urandom);
                bus.irq_fall_en = GW'($urandom);
            end
            for (int i = 0; i < GW; i++) flips[i] = ($urandom_range(0, 19) == 0);
            bus.gpio_i  = bus.gpio_i ^ flips;
            bus.pnd_clr = GW'($urandom & $urandom & $urandom);
            if (n == 900) begin
                async_reset();
            end
            cycle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gpio_debounce.md
GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 Parameter GW, default 32: GPIO width; matches SoC GPIO width.
REQ-002 Parameter PW, default 16: prescaler counter width.
REQ-003 Parameter CW, default 8: per-bit debounce counter width.
REQ-004 Parameter RST_VAL, default '0 (GW bits): reset value of debounced levels.
REQ-005 clk  input  1: system clock; the single clock; all logic on rising edge.
REQ-006 rst  input  1: reset, asynchronous, active-low (0 = reset asserted).
REQ-007 gpio_i  input  GW: GPIO inputs, already synchronized to clk upstream.
REQ-008 cfg_pre  input  PW: prescaler period minus one, in clk cycles.
REQ-009 cfg_thr  input  CW: debounce threshold, in ticks.
REQ-010 irq_rise_en  input  GW: per-bit rising-edge interrupt enable.
REQ-011 irq_fall_en  input  GW: per-bit falling-edge interrupt enable.
REQ-012 pnd_clr  input  GW: per-bit pending clear, write-1-to-clear, one-cycle pulse.
REQ-013 gpio_d  output  GW: debounced levels, registered; feeds SoC gpio_i.
REQ-014 rise  output  GW: one-cycle pulse, debounced 0->1, registered.
REQ-015 fall  output  GW: one-cycle pulse, debounced 1->0, registered.
REQ-016 pnd  output  GW: interrupt pending flags, registered.
REQ-017 irq  output  1: OR of all pnd bits; combinational from pnd only.

Function
REQ-018 Prescaler pcnt: tick = (pcnt >= cfg_pre); on tick pcnt <= 0, else pcnt <= pcnt+1; cfg_pre=0 -> tick every cycle.
REQ-019 cfg_pre lowered below current pcnt -> tick next cycle, then normal period (>= compare, no wrap through 2^PW).
REQ-020 Per bit i, match (gpio_i[i]==gpio_d[i]): cnt[i] <= 0 regardless of tick; no edge.
REQ-021 Mismatch, no tick: cnt[i] held.
REQ-022 Mismatch, tick, cnt[i] < cfg_thr: cnt[i] <= cnt[i]+1.
REQ-023 Mismatch, tick, cnt[i] >= cfg_thr: gpio_d[i] <= gpio_i[i], cnt[i] <= 0, rise[i]/fall[i] asserted next cycle edge, i.e. same cycle gpio_d[i] changes.
REQ-024 Hence stable mismatch must persist for cfg_thr+1 ticks; glitch ending before that -> cnt cleared, gpio_d unchanged.
REQ-025 cfg_pre=0, cfg_thr=0: gpio_d follows gpio_i with exactly 1 clk latency.
REQ-026 cnt never wraps; cfg_thr lowered below cnt -> flip on next mismatch tick.
REQ-027 rise/fall high exactly one cycle per flip; never both for same bit.
REQ-028 pnd[i] next = (pnd[i] & ~pnd_clr[i]) | (rise[i] & irq_rise_en[i]) | (fall[i] & irq_fall_en[i]); simultaneous set and clear -> set wins.
REQ-029 Enable deassert does not clear pnd; only pnd_clr or reset clears.
REQ-030 All bits independent; no cross-bit interaction except shared tick.

Reset
REQ-031 rst=0 asynchronously forces: pcnt=0, cnt=0, gpio_d=RST_VAL, rise=0, fall=0, pnd=0, hence irq=0.
REQ-032 Reset asserted mid-debounce discards progress; after release counting restarts from 0 with pcnt=0.
REQ-033 Input differing from RST_VAL at release debounced normally; produces rise/fall and pnd if enabled.
REQ-034 First tick after release occurs cfg_pre+1 cycles after first active edge (pcnt from 0).

Verification
REQ-035 cfg_pre=0, cfg_thr=0, gpio_i[0] 0->1 -> gpio_d[0]=1 and rise[0]=1 one cycle later, rise[0]=0 following cycle.
REQ-036 cfg_pre=3, cfg_thr=2, gpio_i[5] held high -> gpio_d[5] rises on 3rd tick (cycle 12 after change, +/- tick phase); glitch of 7 cycles -> no change, no rise.
REQ-037 irq_fall_en[7]=1, gpio_i[7] 1->0 debounced -> fall[7] pulse, pnd[7]=1, irq=1; pnd_clr[7] pulse -> pnd[7]=0, irq=0 next cycle.
REQ-038 pnd_clr[3] coincident with rise[3] and irq_rise_en[3]=1 -> pnd[3]=1 (set wins).
REQ-039 rst=0 asserted mid-count with gpio_i=all-ones -> outputs reset immediately; after release with cfg_pre=0, cfg_thr=1 -> all gpio_d=1, all rise pulse at cycle 2.
REQ-040 cfg_thr reduced from 200 to 5 while cnt[2]=50 mismatching -> gpio_d[2] flips on next tick.
